// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI initiator: FSM state encoding,
// frame-length helper and mode line values.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    RECV = 3'd4,
    DONE = 3'd5
  } state_t;

  // Value driven on ss for each direction of the AES engine.
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  // One frame carries a 128-bit block followed by an Nk-word key.
  function automatic int frame_bits(input int nk);
    return 128 + 32 * nk;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Generic W-bit shift register: parallel load, shift left with serial-in,
// parallel out. Load has priority over shift.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Register update: load a new word, or move every bit one place towards the MSB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {q_r[W-2:0], sin};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/spi_master_aes.sv
// Host-side SPI initiator for the AES slave engine. Sends {block,key}
// MSB-first, waits a fixed turnaround, then collects the returned frame
// and presents it with a one-cycle done pulse. All outputs are registered.
module spi_master_aes
  import aes_spi_pkg::*;
#(
  parameter int Nk         = 4,
  parameter int TURNAROUND = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            decrypt,
  input  logic [127:0]    data_in,
  input  logic [32*Nk-1:0] key_in,
  input  logic            abort,
  input  logic            miso,
  output logic            mosi,
  output logic            ss,
  output logic            enable,
  output logic            fin,
  output logic            busy,
  output logic            done,
  output logic [127:0]    data_out,
  output logic [32*Nk-1:0] key_out
);

  localparam int FRAME = frame_bits(Nk);
  localparam int KW    = 32 * Nk;
  localparam int CW    = $clog2(FRAME + 1);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] TURN_LAST  = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            tx_load_s, tx_shift_s, rx_shift_s, cap_s;
  logic            ss_r, ss_s;
  logic            mosi_r, mosi_s;
  logic            en_r, fin_r, fin_s, busy_r, done_r, done_s;
  logic [FRAME-1:0] tx_q, rx_q, rx_next_s;
  logic [127:0]    data_out_r;
  logic [KW-1:0]   key_out_r;

  spi_shift_reg #(.W(FRAME)) u_tx_sr (
    .clock (clock),
    .reset (reset),
    .load  (tx_load_s),
    .shift (tx_shift_s),
    .sin   (1'b0),
    .din   ({data_in, key_in}),
    .q     (tx_q)
  );

  spi_shift_reg #(.W(FRAME)) u_rx_sr (
    .clock (clock),
    .reset (reset),
    .load  (1'b0),
    .shift (rx_shift_s),
    .sin   (miso),
    .din   ({FRAME{1'b0}}),
    .q     (rx_q)
  );

  // The last received bit is folded in directly so the result is ready with done.
  assign rx_next_s = {rx_q[FRAME-2:0], miso};

  // Next-state, counter and next-output decode; abort overrides every non-idle state.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    tx_load_s  = 1'b0;
    tx_shift_s = 1'b0;
    rx_shift_s = 1'b0;
    cap_s      = 1'b0;
    fin_s      = 1'b0;
    done_s     = 1'b0;
    ss_s       = ss_r;
    mosi_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          tx_load_s = 1'b1;
          ss_s      = decrypt;
          mosi_s    = data_in[127];
          cnt_s     = '0;
          state_s   = LOAD;
        end else begin
          ss_s    = 1'b0;
          state_s = IDLE;
        end
      end
      LOAD: begin
        // No shift here: SEND cycle 0 must still present the first bit.
        mosi_s  = tx_q[FRAME-1];
        state_s = SEND;
      end
      SEND: begin
        tx_shift_s = 1'b1;
        if (cnt_r == FRAME_LAST) begin
          cnt_s   = '0;
          state_s = WAIT;
        end else begin
          mosi_s = tx_q[FRAME-2];
          cnt_s  = cnt_r + CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt_r == TURN_LAST) begin
          cnt_s   = '0;
          state_s = RECV;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RECV: begin
        rx_shift_s = 1'b1;
        if (cnt_r == FRAME_LAST) begin
          cnt_s   = '0;
          cap_s   = 1'b1;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        ss_s    = 1'b0;
        state_s = IDLE;
      end
      default: begin
        ss_s    = 1'b0;
        cnt_s   = '0;
        state_s = IDLE;
      end
    endcase

    if ((state_r != IDLE) && abort) begin
      state_s    = IDLE;
      cnt_s      = '0;
      tx_shift_s = 1'b0;
      rx_shift_s = 1'b0;
      cap_s      = 1'b0;
      done_s     = 1'b0;
      ss_s       = 1'b0;
      mosi_s     = 1'b0;
      fin_s      = 1'b1;
    end else begin
      fin_s = 1'b0;
    end
  end

  // State, counter and registered pin outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ss_r    <= 1'b0;
      mosi_r  <= 1'b0;
      en_r    <= 1'b0;
      fin_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ss_r    <= ss_s;
      mosi_r  <= mosi_s;
      en_r    <= (state_s == LOAD);
      fin_r   <= fin_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
    end
  end

  // Result registers: updated only when a full frame has been received.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_r <= '0;
      key_out_r  <= '0;
    end else if (cap_s) begin
      data_out_r <= rx_next_s[FRAME-1:KW];
      key_out_r  <= rx_next_s[KW-1:0];
    end else begin
      data_out_r <= data_out_r;
      key_out_r  <= key_out_r;
    end
  end

  assign mosi     = mosi_r;
  assign ss       = ss_r;
  assign enable   = en_r;
  assign fin      = fin_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign data_out = data_out_r;
  assign key_out  = key_out_r;

endmodule

// File: tb/tb_spi_master_aes.sv
// Self-checking bench for spi_master_aes: one Nk=4 and one Nk=8 instance,
// a transaction-level model with a miso responder, per-cycle comparison,
// and directed scenarios with literal expectations.
module tb_spi_master_aes;

  localparam int T = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start_i [2];
  logic         dec_i   [2];
  logic         abort_i [2];
  logic         miso_i  [2];
  logic [127:0] din_i   [2];
  logic [127:0] key_a_in;
  logic [255:0] key_b_in;

  logic         mosi_o [2];
  logic         ss_o   [2];
  logic         en_o   [2];
  logic         fin_o  [2];
  logic         busy_o [2];
  logic         done_o [2];
  logic [127:0] dout_o [2];
  logic [127:0] kout_a;
  logic [255:0] kout_b;

  spi_master_aes #(.Nk(4), .TURNAROUND(T)) dut_a (
    .clock(clock), .reset(reset), .start(start_i[0]), .decrypt(dec_i[0]),
    .data_in(din_i[0]), .key_in(key_a_in), .abort(abort_i[0]), .miso(miso_i[0]),
    .mosi(mosi_o[0]), .ss(ss_o[0]), .enable(en_o[0]), .fin(fin_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .data_out(dout_o[0]), .key_out(kout_a)
  );

  spi_master_aes #(.Nk(8), .TURNAROUND(T)) dut_b (
    .clock(clock), .reset(reset), .start(start_i[1]), .decrypt(dec_i[1]),
    .data_in(din_i[1]), .key_in(key_b_in), .abort(abort_i[1]), .miso(miso_i[1]),
    .mosi(mosi_o[1]), .ss(ss_o[1]), .enable(en_o[1]), .fin(fin_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .data_out(dout_o[1]), .key_out(kout_b)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- transaction model ----------------
  // m_e counts clocks since the capture edge; a transaction spans
  // e = 0 (enable) .. 2F+T+1 (done).
  int         fl [2] = '{256, 384};
  bit         m_act  [2];
  int         m_e    [2];
  bit         m_mode [2];
  bit         m_fin  [2];
  bit [383:0] m_tx   [2];
  bit [127:0] m_data [2];
  bit [255:0] m_key  [2];
  bit [383:0] resp   [2];

  function automatic bit [383:0] frame_of(input int i);
    if (i == 0) return {128'd0, din_i[0], key_a_in};
    return {din_i[1], key_b_in};
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i]  <= 1'b0;
        m_e[i]    <= 0;
        m_mode[i] <= 1'b0;
        m_fin[i]  <= 1'b0;
        m_data[i] <= '0;
        m_key[i]  <= '0;
      end else begin
        m_fin[i] <= 1'b0;
        if (!m_act[i]) begin
          if (start_i[i]) begin
            m_act[i]  <= 1'b1;
            m_e[i]    <= 0;
            m_tx[i]   <= frame_of(i);
            m_mode[i] <= dec_i[i];
          end
        end else if (abort_i[i]) begin
          m_act[i] <= 1'b0;
          m_fin[i] <= 1'b1;
        end else if (m_e[i] == 2*fl[i] + T + 1) begin
          m_act[i] <= 1'b0;
        end else begin
          m_e[i] <= m_e[i] + 1;
          if (m_e[i] + 1 == 2*fl[i] + T + 1) begin
            m_data[i] <= resp[i][fl[i]-1 -: 128];
            m_key[i]  <= (i == 0) ? {128'd0, resp[i][127:0]} : resp[i][255:0];
          end
        end
      end
    end
  end

  // Responder: returned frame bit j is on miso during receive cycle j.
  function automatic logic miso_bit(input bit act, input int e, input bit [383:0] r, input int f);
    int j;
    j = e - (f + T + 1);
    if (act && j >= 0 && j < f) return r[f-1-j];
    return 1'b1;
  endfunction

  assign miso_i[0] = miso_bit(m_act[0], m_e[0], resp[0], 256);
  assign miso_i[1] = miso_bit(m_act[1], m_e[1], resp[1], 384);

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        int  k;
        bit  mo;
        k  = (m_e[i] == 0) ? 0 : m_e[i] - 1;
        mo = (m_act[i] && m_e[i] <= fl[i]) ? m_tx[i][fl[i]-1-k] : 1'b0;
        chk($sformatf("busy[%0d]", i), {383'd0, busy_o[i]}, {383'd0, m_act[i]});
        chk($sformatf("enable[%0d]", i), {383'd0, en_o[i]}, {383'd0, m_act[i] && m_e[i] == 0});
        chk($sformatf("fin[%0d]", i), {383'd0, fin_o[i]}, {383'd0, m_fin[i]});
        chk($sformatf("done[%0d]", i), {383'd0, done_o[i]},
            {383'd0, m_act[i] && m_e[i] == 2*fl[i] + T + 1});
        chk($sformatf("ss[%0d]", i), {383'd0, ss_o[i]}, {383'd0, m_act[i] && m_mode[i]});
        chk($sformatf("mosi[%0d]", i), {383'd0, mosi_o[i]}, {383'd0, mo});
        chk($sformatf("data_out[%0d]", i), {256'd0, dout_o[i]}, {256'd0, m_data[i]});
      end
      chk("key_out[0]", {256'd0, kout_a}, {128'd0, m_key[0]});
      chk("key_out[1]", {128'd0, kout_b}, {128'd0, m_key[1]});
    end
  end

  // ---------------- directed stimulus ----------------
  logic [383:0] strm;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start one transaction on instance i; n counts edges with the capture edge as 1.
  task automatic run(input int i, input int budget, input int mid_start,
                     output int done_at, output int ndone, output int nen);
    done_at = -1; ndone = 0; nen = 0; strm = '0;
    start_i[i] = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      start_i[i] = (n == mid_start);
      if (en_o[i] === 1'b1) nen++;
      if (done_o[i] === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      if (n >= 2 && n <= fl[i] + 1) strm[fl[i]-n+1] = mosi_o[i];
    end
    start_i[i] = 1'b0;
  endtask

  initial begin
    int da, nd, ne, d1, d2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; dec_i[i] = 1'b0; abort_i[i] = 1'b0; din_i[i] = '0;
      resp[i] = '0;
    end
    key_a_in = '0; key_b_in = '0;
    repeat (3) tick();
    chk("reset busy", {383'd0, busy_o[0]}, 384'd0);
    chk("reset mosi", {383'd0, mosi_o[0]}, 384'd0);
    chk("reset done", {383'd0, done_o[1]}, 384'd0);
    chk("reset data_out", {256'd0, dout_o[0]}, 384'd0);
    reset = 1'b0;
    tick();

    // Serialisation / deserialisation, encrypt, Nk=4; a start while busy is ignored.
    din_i[0] = 128'h00112233445566778899aabbccddeeff;
    key_a_in = 128'h000102030405060708090a0b0c0d0e0f;
    dec_i[0] = 1'b0;
    resp[0]  = {128'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f};
    run(0, 700, 100, da, nd, ne);
    chk("t1 done cycle", 384'(da), 384'd518);
    chk("t1 done count", 384'(nd), 384'd1);
    chk("t1 enable count", 384'(ne), 384'd1);
    chk("t1 mosi frame", {128'd0, strm[255:0]},
        {128'd0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f});
    chk("t1 mosi bit0", {383'd0, strm[255]}, 384'd0);
    chk("t1 mosi bit11", {383'd0, strm[244]}, 384'd1);
    chk("t1 data_out", {256'd0, dout_o[0]}, {256'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a});
    chk("t1 key_out", {256'd0, kout_a}, {256'd0, 128'h000102030405060708090a0b0c0d0e0f});

    // Decrypt, Nk=8.
    din_i[1] = 128'h00112233445566778899aabbccddeeff;
    key_b_in = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    dec_i[1] = 1'b1;
    resp[1]  = {128'h8ea2b7ca516745bfeafc49904b496089,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
    run(1, 900, 0, da, nd, ne);
    chk("t2 done cycle", 384'(da), 384'd774);
    chk("t2 done count", 384'(nd), 384'd1);
    chk("t2 enable count", 384'(ne), 384'd1);
    chk("t2 mosi frame", strm,
        {128'h00112233445566778899aabbccddeeff,
         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f});
    chk("t2 data_out", {256'd0, dout_o[1]}, {256'd0, 128'h8ea2b7ca516745bfeafc49904b496089});
    dec_i[1] = 1'b0;

    // Abort at SEND cycle 50.
    resp[0] = {128'd0, 128'hdeadbeef0123456789abcdeff0e1d2c3, key_a_in};
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    repeat (51) tick();
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    chk("t3 fin high", {383'd0, fin_o[0]}, 384'd1);
    chk("t3 busy low", {383'd0, busy_o[0]}, 384'd0);
    tick();
    chk("t3 fin one cycle", {383'd0, fin_o[0]}, 384'd0);
    nd = 0;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (done_o[0] === 1'b1) nd++;
    end
    chk("t3 no done", 384'(nd), 384'd0);
    chk("t3 data_out kept", {256'd0, dout_o[0]}, {256'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a});
    run(0, 600, 0, da, nd, ne);
    chk("t3 restart done cycle", 384'(da), 384'd518);
    chk("t3 restart data_out", {256'd0, dout_o[0]}, {256'd0, 128'hdeadbeef0123456789abcdeff0e1d2c3});

    // Asynchronous reset in the middle of RECV.
    dec_i[0] = 1'b1;
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    repeat (280) tick();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t4 busy", {383'd0, busy_o[0]}, 384'd0);
    chk("t4 ss", {383'd0, ss_o[0]}, 384'd0);
    chk("t4 mosi/en/fin/done", {380'd0, mosi_o[0], en_o[0], fin_o[0], done_o[0]}, 384'd0);
    chk("t4 data_out", {256'd0, dout_o[0]}, 384'd0);
    chk("t4 key_out", {256'd0, kout_a}, 384'd0);
    tick();
    reset = 1'b0;
    dec_i[0] = 1'b0;
    tick();
    chk("t4 no fin", {383'd0, fin_o[0]}, 384'd0);

    // Back-to-back with start held high.
    resp[0] = {128'd0, 128'h3925841d02dc09fbdc118597196a0b32, key_a_in};
    d1 = -1; d2 = -1;
    start_i[0] = 1'b1;
    for (int n = 1; n <= 1200 && d2 < 0; n++) begin
      tick();
      if (done_o[0] === 1'b1) begin
        if (d1 < 0) d1 = n;
        else d2 = n;
      end
    end
    start_i[0] = 1'b0;
    chk("t5 first done", 384'(d1), 384'd518);
    chk("t5 done spacing", 384'(d2 - d1), 384'd519);
    chk("t5 data_out", {256'd0, dout_o[0]}, {256'd0, 128'h3925841d02dc09fbdc118597196a0b32});
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
